// File: rtl/axi_tensor_wr_stream.sv
// axi_tensor_wr_stream
// AXI4 write-back master that drains PE results from a valid/ready stream into
// DRAM. Each transfer starts at a configurable base address, runs for an
// arbitrary number of beats, and is split into bursts that never exceed
// MAX_BURST beats and never cross a 4 KB boundary. Only one burst is in flight
// at a time: AW, then its W beats, then its B response, then the next AW.

module axi_tensor_wr_stream #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int MAX_BURST  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    // Transfer control
    input  logic                      start,
    input  logic                      half_mode,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [CNT_WIDTH-1:0]      num_beats,

    // Result stream from the PE sequencer
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,

    // AXI write address channel
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic [2:0]                axi_awsize,
    output logic [1:0]                axi_awburst,

    // AXI write data channel
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wlast,

    // AXI write response channel
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    input  logic [1:0]                axi_bresp,

    // Status
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // Bytes per beat and the number of address bits covered by one beat.
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);

    // Comparison width wide enough for both the beat count and a burst length.
    localparam int CW = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t                  state;

    // Address of the next burst and beats still to be issued after it.
    logic [ADDR_WIDTH-1:0]   addr;
    logic [CNT_WIDTH-1:0]    rem;

    // Length of the current burst in beats (1..256) and beats already sent.
    logic [8:0]              len;
    logic [8:0]              beat_cnt;

    // Transfer parameters as seen on a start pulse.
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [CNT_WIDTH-1:0]    start_rem;
    logic [8:0]              start_len;

    // Length of the following burst, from the already advanced addr/rem.
    logic [8:0]              next_len;

    logic                    w_hs;
    logic                    last_beat;

    // Only bresp[1] distinguishes an error; the low bit carries no meaning here.
    logic                    unused_bresp;

    // Burst length: limited by the remaining count, the maximum burst size and
    // the distance to the next 4 KB page. The address is always beat aligned,
    // so the page room is at least one beat.
    function automatic logic [8:0] calc_len(input logic [11:0]          page_off,
                                            input logic [CNT_WIDTH-1:0] r);
        logic [12:0]   room;
        logic [CW-1:0] l;
        logic [CW-1:0] rr;
        room = 13'd4096 - {1'b0, page_off};
        l    = CW'(room >> OFFS);
        rr   = CW'(r);
        if (l > CW'(MAX_BURST)) begin
            l = CW'(MAX_BURST);
        end
        if (rr < l) begin
            l = rr;
        end
        return l[8:0];
    endfunction

    assign unused_bresp = axi_bresp[0];

    assign start_addr = base_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign start_rem  = half_mode ? (num_beats >> 1) : num_beats;
    assign start_len  = calc_len(start_addr[11:0], start_rem);
    assign next_len   = calc_len(addr[11:0], rem);

    assign last_beat  = (beat_cnt == (len - 9'd1));

    // The W channel is a straight pass-through of the result stream while a
    // burst is being written; outside DATA the stream is held off.
    assign axi_wvalid = (state == DATA) && in_valid;
    assign in_ready   = (state == DATA) && axi_wready;
    assign axi_wdata  = in_data;
    assign axi_wlast  = (state == DATA) && last_beat;
    assign w_hs       = axi_wvalid && axi_wready;

    assign axi_awsize  = 3'(OFFS);
    assign axi_awburst = 2'b01;
    assign axi_wstrb   = '1;

    // Transfer sequencer: launches bursts, counts beats, tracks responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            rem         <= '0;
            len         <= '0;
            beat_cnt    <= '0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_bready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_rem == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr        <= start_addr;
                            rem         <= start_rem;
                            len         <= start_len;
                            axi_awaddr  <= start_addr;
                            axi_awlen   <= 8'(start_len - 9'd1);
                            axi_awvalid <= 1'b1;
                            busy        <= 1'b1;
                            err         <= 1'b0;
                            state       <= ADDR;
                        end
                    end
                end

                ADDR: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= DATA;
                    end
                end

                DATA: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            addr       <= addr + (ADDR_WIDTH'(len) << OFFS);
                            rem        <= rem - CNT_WIDTH'(len);
                            axi_bready <= 1'b1;
                            state      <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end

                RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (axi_bresp[1]) begin
                            err <= 1'b1;
                        end
                        if (rem == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            len         <= next_len;
                            axi_awaddr  <= addr;
                            axi_awlen   <= 8'(next_len - 9'd1);
                            axi_awvalid <= 1'b1;
                            state       <= ADDR;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
